regfile_write_port: RTL and testbench
=====================================

# regfile_write_port

Write side of the 32 x 32-bit CPU register file. It accepts register writes over a valid/ready handshake and buffers them in a 2-entry in-order queue. It commits at most one write per cycle through a 5-to-32 one-hot decoder into the register array, and exposes all 32 registers as a flattened bus for the read-side 32:1 selectors. Register 0 is hardwired to zero, and per-register pending flags let hazard logic see writes that are queued but not yet committed.

## Interface
- No parameters; width 32, depth 32 and queue depth 2 are fixed.
- clock  in  1  single clock, all state updates on its rising edge.
- ctrl_reset  in  1  synchronous reset, active-high.
- wr_valid  in  1  a write request is present on wr_addr/wr_data.
- wr_ready  out  1  the block can accept a request this cycle.
- wr_addr  in  5  destination register index.
- wr_data  in  32  write data.
- regs_flat  out  1024  register k on bits [32k+31:32k]; bits [31:0] always 0.
- pending  out  32  bit k = 1 while a queued, uncommitted write targets register k; bit 0 always 0.
- q_count  out  2  number of queued writes (0..2).

## Operation
- Clock and reset: one clock, `clock`; reset is synchronous and active-high, `ctrl_reset`.
- Accept: a request is accepted when wr_valid && wr_ready at a rising edge. wr_ready = !ctrl_reset && (q_count != 2).
- wr_ready depends only on registered state; a commit in the same cycle does not open a slot when full.
- Queue: 2-entry FIFO of {addr, data}, with head pointer, tail pointer and count. The tail wraps 1 -> 0 and the head wraps 1 -> 0.
- Commit: every cycle with q_count > 0, pop the head. Decode addr to a one-hot 32-bit enable, then write data into the enabled register.
- Register 0: a commit with addr = 0 pops the entry and leaves r0 unchanged.
- Simultaneous accept and commit: allowed when q_count is 1. Count stays 1, the head entry commits and the new entry becomes the head.
- Pending flags are recomputed each cycle from the queue contents after the update. Bit k is 1 iff a valid queue entry has addr = k and k != 0.
  - Two queued writes to the same register keep that bit set until the second commits.
- Ordering: commits follow acceptance order. For two writes to the same register, the later one wins.
- Reset: all 32 registers go to 0, q_count to 0 and pending to 0, and head and tail return to 0. wr_ready is 0 while ctrl_reset is high.
  - Queued writes are discarded and never committed.
  - A request presented during the reset cycle is not accepted.
- Reset values: regs_flat = 0, pending = 0, q_count = 0, wr_ready = 0 during reset and 1 in the first cycle after it.

## Timing
- Write latency from an empty queue:
  - Request accepted at edge N.
  - q_count = 1 and pending[addr] = 1 after N.
  - Commit at edge N+1; the register value is visible on regs_flat after N+1, with pending cleared and q_count = 0.
- Sustained stream: a request every cycle gives 1 write/cycle throughput. q_count holds at 1 and wr_ready stays high.
- Back-pressure: the queue reaches 2 only if commit is blocked. Commit is never blocked in this block, so q_count = 2 arises only transiently, e.g. a test hook. It is still handled: with q_count = 2, wr_ready = 0 and the next edge commits the head, giving q_count = 1.
- regs_flat, pending and q_count are registered outputs with no combinational path from inputs. wr_ready is combinational from q_count and ctrl_reset only.

## Test plan
- Reset: hold ctrl_reset 2 cycles with wr_valid = 1, addr 5, data 0xFFFFFFFF.
  - During reset: wr_ready = 0.
  - After reset: all regs_flat = 0, pending = 0, q_count = 0, and r5 still 0.
- Single write: write addr 7, data 0xDEADBEEF at edge N.
  - After N: pending[7] = 1, r7 = 0.
  - After N+1: r7 = 0xDEADBEEF and pending = 0.
- Register 0: write addr 0, data 0x12345678.
  - Accepted; pending stays 0; after commit r0 = 0 and q_count = 0.
- Back-to-back: write r3 = 1, r3 = 2, r31 = 0xA5A5A5A5 on consecutive cycles.
  - wr_ready stays 1 throughout.
  - Final r3 = 2 and r31 = 0xA5A5A5A5.
  - pending[3] is 1 from the first accept until the second r3 commit.
- Reset mid-operation: accept a write to r9, then assert ctrl_reset on the next edge.
  - r9 remains 0, q_count = 0, pending[9] = 0.
- Full sweep: write reg k = 0x100 + k for k = 0..31, one per cycle, then idle 2 cycles.
  - regs_flat matches for k = 1..31, r0 = 0, and each one-hot enable hits only its own register.

Source files
------------

// File: rtl/regfile_write_port.sv
// regfile_write_port: 32x32 register file write side with a 2-entry in-order write queue and pending flags
module regfile_write_port (
    input  logic          clock,
    input  logic          ctrl_reset,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [4:0]    wr_addr,
    input  logic [31:0]   wr_data,
    output logic [1023:0] regs_flat,
    output logic [31:0]   pending,
    output logic [1:0]    q_count
);
    logic [4:0]  q_addr [2];
    logic [31:0] q_data [2];
    logic [4:0]  addr_n [2];
    logic [31:0] regs [1:31];
    logic [31:0] wr_en, pending_n;
    logic [1:0]  count_n;
    logic        head, tail, head_n, tail_n, accept, commit;

    assign wr_ready = !ctrl_reset && q_count != 2'd2;
    assign accept   = wr_valid && wr_ready;
    assign commit   = q_count != 2'd0;
    assign wr_en    = commit ? 32'd1 << q_addr[head] : 32'd0;

    // Pending flags are derived from the queue as it will look after this edge.
    always_comb begin
        addr_n[0] = (accept && !tail) ? wr_addr : q_addr[0];
        addr_n[1] = (accept && tail) ? wr_addr : q_addr[1];
        head_n    = head ^ commit;
        tail_n    = tail ^ accept;
        count_n   = q_count + {1'b0, accept} - {1'b0, commit};
        pending_n = ((count_n != 2'd0) ? 32'd1 << addr_n[head_n] : 32'd0)
                  | ((count_n == 2'd2) ? 32'd1 << addr_n[~head_n] : 32'd0);
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            head    <= 1'b0;
            tail    <= 1'b0;
            q_count <= 2'd0;
            pending <= 32'd0;
        end else begin
            head      <= head_n;
            tail      <= tail_n;
            q_count   <= count_n;
            pending   <= pending_n & ~32'd1;
            q_addr[0] <= addr_n[0];
            q_addr[1] <= addr_n[1];
            if (accept)
                q_data[tail] <= wr_data;
        end
    end

    assign regs_flat[31:0] = 32'd0;

    for (genvar i = 1; i < 32; i++) begin : g_reg
        always_ff @(posedge clock) begin
            if (ctrl_reset)
                regs[i] <= 32'd0;
            else if (wr_en[i])
                regs[i] <= q_data[head];
        end
        assign regs_flat[32*i +: 32] = regs[i];
    end
endmodule

// File: tb/tb_regfile_write_port.sv
// tb_regfile_write_port: directed checks of the register file write port
module tb_regfile_write_port;
    logic          clock = 1'b0;
    logic          ctrl_reset;
    logic          wr_valid;
    logic          wr_ready;
    logic [4:0]    wr_addr;
    logic [31:0]   wr_data;
    logic [1023:0] regs_flat;
    logic [31:0]   pending;
    logic [1:0]    q_count;
    int            n_vec = 0;
    int            n_miss = 0;

    regfile_write_port dut (
        .clock(clock),
        .ctrl_reset(ctrl_reset),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .regs_flat(regs_flat),
        .pending(pending),
        .q_count(q_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] rv(input int k);
        return regs_flat[32*k +: 32];
    endfunction

    task automatic put(input logic [4:0] a, input logic [31:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
    endtask

    initial begin
        ctrl_reset = 1'b1;
        put(5'd5, 32'hFFFF_FFFF);
        #1;
        check("ready_in_reset0", 32'(wr_ready), 32'd0);
        tick;
        check("ready_in_reset1", 32'(wr_ready), 32'd0);
        tick;
        ctrl_reset = 1'b0;
        wr_valid   = 1'b0;
        #1;
        check("ready_after_reset", 32'(wr_ready), 32'd1);
        check("qcount_after_reset", 32'(q_count), 32'd0);
        check("pending_after_reset", pending, 32'd0);
        for (int k = 0; k < 32; k++)
            check($sformatf("reset_r%0d", k), rv(k), 32'd0);

        put(5'd7, 32'hDEAD_BEEF);
        tick;
        wr_valid = 1'b0;
        check("single_pending", pending, 32'h0000_0080);
        check("single_r7_early", rv(7), 32'd0);
        check("single_qcount1", 32'(q_count), 32'd1);
        tick;
        check("single_r7", rv(7), 32'hDEAD_BEEF);
        check("single_pending_clr", pending, 32'd0);
        check("single_qcount0", 32'(q_count), 32'd0);

        put(5'd0, 32'h1234_5678);
        tick;
        wr_valid = 1'b0;
        check("r0_pending", pending, 32'd0);
        check("r0_qcount1", 32'(q_count), 32'd1);
        tick;
        check("r0_value", rv(0), 32'd0);
        check("r0_qcount0", 32'(q_count), 32'd0);

        put(5'd3, 32'd1);
        check("b2b_ready0", 32'(wr_ready), 32'd1);
        tick;
        check("b2b_pending_a", pending, 32'h0000_0008);
        put(5'd3, 32'd2);
        check("b2b_ready1", 32'(wr_ready), 32'd1);
        tick;
        check("b2b_pending_b", pending, 32'h0000_0008);
        check("b2b_r3_first", rv(3), 32'd1);
        check("b2b_qcount", 32'(q_count), 32'd1);
        put(5'd31, 32'hA5A5_A5A5);
        check("b2b_ready2", 32'(wr_ready), 32'd1);
        tick;
        wr_valid = 1'b0;
        check("b2b_pending_c", pending, 32'h8000_0000);
        check("b2b_r3_final", rv(3), 32'd2);
        tick;
        check("b2b_r31", rv(31), 32'hA5A5_A5A5);
        check("b2b_pending_clr", pending, 32'd0);
        check("b2b_r3_kept", rv(3), 32'd2);

        put(5'd9, 32'h0000_0099);
        tick;
        wr_valid   = 1'b0;
        ctrl_reset = 1'b1;
        #1;
        check("mid_ready_in_reset", 32'(wr_ready), 32'd0);
        tick;
        ctrl_reset = 1'b0;
        check("mid_r9", rv(9), 32'd0);
        check("mid_qcount", 32'(q_count), 32'd0);
        check("mid_pending", pending, 32'd0);
        check("mid_r7_cleared", rv(7), 32'd0);

        for (int k = 0; k < 32; k++) begin
            put(5'(k), 32'h100 + 32'(k));
            tick;
        end
        wr_valid = 1'b0;
        tick;
        tick;
        for (int k = 0; k < 32; k++)
            check($sformatf("sweep_r%0d", k), rv(k), (k == 0) ? 32'd0 : 32'h100 + 32'(k));
        check("sweep_qcount", 32'(q_count), 32'd0);
        check("sweep_pending", pending, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
